multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32I core: steps FETCH/DECODE/EXEC/MEM/WB around the instruction decoder,

---
 rtl/riscv_pkg.sv | 43 ++++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/multicycle_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcodes, sequencer states, write-back and error encodings.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_IMM  = 2'b11
  } wb_sel_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_IMEM_TO = 2'b10,
    ERR_DMEM_TO = 2'b11
  } err_t;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R)      || (op == OP_IMM)   || (op == OP_LOAD) ||
           (op == OP_STORE)  || (op == OP_BRANCH) || (op == OP_LUI) ||
           (op == OP_AUIPC)  || (op == OP_JAL)   || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for outstanding memory requests; expired flags the last allowed no-ack cycle.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMR_W          = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [TMR_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (count) begin
      cnt_reg <= cnt_reg + TMR_W'(1);
    end
  end

  // Counter holds the number of earlier no-ack cycles, so this cycle is the N-th.
  assign expired = count && (cnt_reg == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer FETCH/DECODE/EXEC/MEM/WB with sticky trap.
// Optional INSTRET_COUNTER_EN adds a 64-bit retired-instruction counter output.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMR_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        br_taken,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [2:0]  dmem_size,
  output logic        alu_a_pc,
  output logic        alu_b_imm,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  err_code
`ifdef INSTRET_COUNTER_EN
  ,
  output logic [63:0] instret
`endif
);

  state_t     state_reg, state_next;
  err_t       err_reg, err_next;
  logic [6:0] op_reg;
  logic [2:0] f3_reg;
  logic       waiting, ack_now, tmr_count, tmr_expired;

  assign waiting   = (state_reg == ST_FETCH) || (state_reg == ST_MEM);
  assign ack_now   = (state_reg == ST_FETCH) ? imem_ack : dmem_ack;
  assign tmr_count = waiting && !ack_now;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!tmr_count),
    .count  (tmr_count),
    .expired(tmr_expired)
  );

  // Opcode/funct3 captured at DECODE so later states ignore input changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_FETCH;
      err_reg   <= ERR_NONE;
      op_reg    <= '0;
      f3_reg    <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      if (state_reg == ST_DECODE) begin
        op_reg <= opcode;
        f3_reg <= funct3;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_size  = 3'b000;
    alu_a_pc   = 1'b0;
    alu_b_imm  = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = WB_ALU;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        if (imem_ack) begin
          state_next = ST_DECODE;
        end else if (tmr_expired) begin
          state_next = ST_TRAP;
          err_next   = ERR_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if (!is_legal(opcode)) begin
          state_next = ST_TRAP;
          err_next   = ERR_ILLEGAL;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_a_pc  = (op_reg == OP_AUIPC) || (op_reg == OP_JAL) || (op_reg == OP_BRANCH);
        alu_b_imm = (op_reg != OP_R);
        if ((op_reg == OP_LOAD) || (op_reg == OP_STORE)) begin
          state_next = ST_MEM;
        end else if (op_reg == OP_BRANCH) begin
          pc_we      = 1'b1;
          pc_sel     = br_taken;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = (op_reg == OP_STORE);
        dmem_size = f3_reg;
        if (dmem_ack) begin
          if (op_reg == OP_STORE) begin
            pc_we      = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (tmr_expired) begin
          state_next = ST_TRAP;
          err_next   = ERR_DMEM_TO;
        end
      end
      ST_WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        pc_sel     = (op_reg == OP_JAL) || (op_reg == OP_JALR);
        state_next = ST_FETCH;
        if (op_reg == OP_LUI) begin
          wb_sel = WB_IMM;
        end else if ((op_reg == OP_JAL) || (op_reg == OP_JALR)) begin
          wb_sel = WB_PC4;
        end else if (op_reg == OP_LOAD) begin
          wb_sel = WB_LOAD;
        end
      end
      ST_TRAP: begin
        state_next = ST_TRAP;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
    // The reset state is FETCH, which would otherwise request; keep the bus quiet during reset.
    if (rst) begin
      imem_req  = 1'b0;
      ir_we     = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      dmem_size = 3'b000;
      alu_a_pc  = 1'b0;
      alu_b_imm = 1'b0;
      reg_we    = 1'b0;
      wb_sel    = WB_ALU;
      pc_we     = 1'b0;
      pc_sel    = 1'b0;
    end
  end

  assign state    = state_reg;
  assign trap     = (state_reg == ST_TRAP);
  assign err_code = err_reg;

`ifdef INSTRET_COUNTER_EN
  logic [63:0] instret_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_reg <= '0;
    end else if (pc_we) begin
      instret_reg <= instret_reg + 64'd1;
    end
  end

  assign instret = instret_reg;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction timeline model builds step tables.
module tb_multicycle_ctrl;
  import riscv_pkg::*;

  localparam int T = 16;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic [2:0] size;
    logic       a_pc;
    logic       b_imm;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       pc_we;
    logic       pc_sel;
    logic       trap;
    logic [1:0] err;
  } outs_t;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        iack;
    logic        dack;
    logic        br;
    outs_t       exp;
    logic [63:0] instret;
    logic        last;
    string       name;
  } step_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        br_taken = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic        imem_req, ir_we, dmem_req, dmem_we, alu_a_pc, alu_b_imm, reg_we, pc_we, pc_sel, trap;
  logic [2:0]  dmem_size, state;
  logic [1:0]  wb_sel, err_code;
`ifdef INSTRET_COUNTER_EN
  logic [63:0] instret;
`endif

  step_t       q[$];
  longint      mcnt = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_CYCLES(T), .TMR_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size), .alu_a_pc(alu_a_pc),
    .alu_b_imm(alu_b_imm), .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
    .state(state), .trap(trap), .err_code(err_code)
`ifdef INSTRET_COUNTER_EN
    , .instret(instret)
`endif
  );

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic outs_t base(input logic [2:0] st);
    outs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic logic legal(input logic [6:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
  endfunction

  task automatic push(input logic r, input logic [6:0] op, input logic [2:0] f3, input logic ia,
                      input logic da, input logic br, input outs_t e, input string nm);
    step_t s;
    if (r) mcnt = 0;
    s.rst = r; s.op = op; s.f3 = f3; s.iack = ia; s.dack = da; s.br = br;
    s.exp = e; s.instret = 64'(mcnt); s.last = 1'b0; s.name = nm;
    if (e.pc_we) mcnt++;
    q.push_back(s);
  endtask

  task automatic mark_last();
    q[q.size()-1].last = 1'b1;
  endtask

  task automatic push_reset(input string nm);
    push(1'b1, 7'h00, 3'd0, rb(), rb(), rb(), base(ST_FETCH), nm);
  endtask

  // Trapped: acks are ignored for a few cycles, then only reset recovers.
  task automatic gen_trap(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] code,
                          input string nm);
    outs_t e;
    e = base(ST_TRAP);
    e.trap = 1'b1;
    e.err = code;
    for (int k = 0; k < 3; k++) push(1'b0, op, f3, 1'b1, rb(), rb(), e, nm);
    push_reset(nm);
    mark_last();
  endtask

  task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic br,
                           input int iw, input int dw, input bit abort_mem, input string nm);
    outs_t e;
    bit    st_op;
    st_op = (op == OP_STORE);
    for (int k = 0; k < iw && k < T; k++) begin
      e = base(ST_FETCH); e.imem_req = 1'b1;
      push(1'b0, op, f3, 1'b0, rb(), rb(), e, nm);
    end
    if (iw >= T) begin gen_trap(op, f3, ERR_IMEM_TO, nm); return; end
    e = base(ST_FETCH); e.imem_req = 1'b1; e.ir_we = 1'b1;
    push(1'b0, op, f3, 1'b1, rb(), rb(), e, nm);
    push(1'b0, op, f3, rb(), rb(), rb(), base(ST_DECODE), nm);
    if (!legal(op)) begin gen_trap(op, f3, ERR_ILLEGAL, nm); return; end
    e = base(ST_EXEC);
    e.a_pc  = (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_BRANCH);
    e.b_imm = (op != OP_R);
    if (op == OP_BRANCH) begin
      e.pc_we = 1'b1; e.pc_sel = br;
      push(1'b0, op, f3, rb(), rb(), br, e, nm);
      mark_last();
      return;
    end
    push(1'b0, op, f3, rb(), rb(), br, e, nm);
    if (op == OP_LOAD || st_op) begin
      for (int k = 0; k < dw && k < T; k++) begin
        e = base(ST_MEM); e.dmem_req = 1'b1; e.dmem_we = st_op; e.size = f3;
        push(1'b0, op, f3, rb(), 1'b0, rb(), e, nm);
        if (abort_mem) begin push_reset(nm); mark_last(); return; end
      end
      if (dw >= T) begin gen_trap(op, f3, ERR_DMEM_TO, nm); return; end
      e = base(ST_MEM); e.dmem_req = 1'b1; e.dmem_we = st_op; e.size = f3;
      e.pc_we = st_op;
      push(1'b0, op, f3, rb(), 1'b1, rb(), e, nm);
      if (st_op) begin mark_last(); return; end
    end
    e = base(ST_WB);
    e.reg_we = 1'b1; e.pc_we = 1'b1;
    e.pc_sel = (op == OP_JAL) || (op == OP_JALR);
    if (op == OP_LUI) e.wb_sel = 2'b11;
    else if (op == OP_JAL || op == OP_JALR) e.wb_sel = 2'b10;
    else if (op == OP_LOAD) e.wb_sel = 2'b01;
    push(1'b0, op, f3, rb(), rb(), rb(), e, nm);
    mark_last();
  endtask

  task automatic apply_all();
    outs_t got;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rst = q[i].rst; opcode = q[i].op; funct3 = q[i].f3;
      imem_ack = q[i].iack; dmem_ack = q[i].dack; br_taken = q[i].br;
      #1;
      got = {state, imem_req, ir_we, dmem_req, dmem_we, dmem_size, alu_a_pc, alu_b_imm,
             reg_we, wb_sel, pc_we, pc_sel, trap, err_code};
      checks++;
      if (got !== q[i].exp) begin
        errors++;
        $display("FAIL %s step %0d outputs got %h expected %h", q[i].name, i, got, q[i].exp);
      end
`ifdef INSTRET_COUNTER_EN
      checks++;
      if (instret !== q[i].instret) begin
        errors++;
        $display("FAIL %s step %0d instret got %0d expected %0d", q[i].name, i, instret, q[i].instret);
      end
`endif
      if (q[i].last) $display("txn %s completed at step %0d", q[i].name, i);
    end
    q.delete();
  endtask

  initial begin
    logic [6:0] ops[10];
    int         r;
    int         iw;
    int         dw;
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, 7'h7f};

    push_reset("reset"); mark_last();
    gen_instr(OP_IMM,    3'd0, 1'b0, 0, 0, 1'b0, "addi");
    gen_instr(OP_LOAD,   3'd2, 1'b0, 0, 3, 1'b0, "lw_wait3");
    gen_instr(OP_BRANCH, 3'd0, 1'b1, 0, 0, 1'b0, "beq_taken");
    gen_instr(OP_BRANCH, 3'd0, 1'b0, 0, 0, 1'b0, "beq_not_taken");
    gen_instr(OP_R,      3'd0, 1'b0, 1, 0, 1'b0, "add");
    gen_instr(OP_LUI,    3'd0, 1'b0, 0, 0, 1'b0, "lui");
    gen_instr(OP_AUIPC,  3'd0, 1'b0, 0, 0, 1'b0, "auipc");
    gen_instr(OP_JAL,    3'd0, 1'b0, 0, 0, 1'b0, "jal");
    gen_instr(OP_JALR,   3'd0, 1'b0, 2, 0, 1'b0, "jalr");
    gen_instr(OP_STORE,  3'd1, 1'b0, 0, 0, 1'b0, "sh");
    gen_instr(7'h7f,     3'd0, 1'b0, 0, 0, 1'b0, "illegal");
    gen_instr(OP_IMM,    3'd0, 1'b0, T, 0, 1'b0, "imem_timeout");
    gen_instr(OP_IMM,    3'd0, 1'b0, T - 1, 0, 1'b0, "imem_ack_last");
    gen_instr(OP_LOAD,   3'd4, 1'b0, 0, T, 1'b0, "dmem_timeout");
    gen_instr(OP_LOAD,   3'd4, 1'b0, 0, T - 1, 1'b0, "dmem_ack_last");
    gen_instr(OP_IMM,    3'd0, 1'b0, 0, 0, 1'b0, "addi2");
    gen_instr(OP_STORE,  3'd2, 1'b0, 0, 5, 1'b1, "sw_reset_mid_mem");
    gen_instr(OP_IMM,    3'd0, 1'b0, 0, 0, 1'b0, "addi_after_rst");
    apply_all();

    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 19);
      iw = (r == 19) ? T : (r % 4);
      r  = $urandom_range(0, 19);
      dw = (r == 19) ? T : (r % 4);
      gen_instr(ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), rb(), iw, dw, 1'b0,
                $sformatf("rand%0d", n));
    end
    apply_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
